// File: rtl/sklansky_frame_accumulator_pkg.sv
// rtl/sklansky_frame_accumulator_pkg.sv - shared types and widths for the frame accumulator
//
// Purpose: FSM state encoding, adder width and beat counter width shared by
//          the accumulator top, its control sub-module and its bus interface.
// Ports:   none (package).
package sklansky_frame_accumulator_pkg;

  localparam int DATA_W = 16;
  localparam int BEAT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/sklansky_frame_accumulator_if.sv
// rtl/sklansky_frame_accumulator_if.sv - sample-in / result-out stream bundle
//
// Purpose: groups the input sample stream and the output result stream.
// Signals: in_valid/in_ready/in_data/in_last  - sample stream (source -> block)
//          out_valid/out_ready                 - result handshake (block -> consumer)
//          out_sum/out_cnt/out_ovf             - frame total, beat count, saturation flag
// Modports: master = source and consumer side, slave = accumulator side.
interface sklansky_frame_accumulator_if
  import sklansky_frame_accumulator_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W+CNT_W-1:0] out_sum;
  logic [BEAT_W-1:0]       out_cnt;
  logic                    out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

endinterface

// File: rtl/SklanskyAdder_16.sv
// rtl/SklanskyAdder_16.sv - combinational 16-bit Sklansky prefix adder
//
// Purpose: sum = a + b (no carry-in), carry-out on o_co; purely combinational.
// Ports:   i_a, i_b - 16-bit operands
//          o_sum    - 16-bit sum
//          o_co     - carry out of bit 15
module SklanskyAdder_16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum,
  output logic        o_co
);

  logic [15:0] w_p0;
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_gn;
  logic [15:0] w_pn;

  // Four divide-and-conquer levels: at level l every bit whose l-th index bit
  // is set absorbs the group (g,p) of the last bit of the preceding 2^l block.
  always_comb begin
    w_p0 = i_a ^ i_b;
    w_g  = i_a & i_b;
    w_p  = w_p0;
    w_gn = w_g;
    w_pn = w_p;
    for (int l = 0; l < 4; l++) begin
      w_gn = w_g;
      w_pn = w_p;
      for (int i = 0; i < 16; i++) begin
        if (((i >> l) & 1) != 0) begin
          w_gn[i] = w_g[i] | (w_p[i] & w_g[((i >> l) << l) - 1]);
          w_pn[i] = w_p[i] & w_p[((i >> l) << l) - 1];
        end
      end
      w_g = w_gn;
      w_p = w_pn;
    end
    o_sum = w_p0 ^ {w_g[14:0], 1'b0};
    o_co  = w_g[15];
  end

endmodule

// File: rtl/sklansky_frame_accumulator_ctrl.sv
// rtl/sklansky_frame_accumulator_ctrl.sv - frame FSM and beat counter
//
// Purpose: tracks the frame state, counts accepted beats and produces the
//          accept / clear / close strobes that steer the datapath.
// Ports:   i_clk, i_rst              - clock, synchronous active-high reset
//          i_in_valid, i_in_last     - input stream qualifiers
//          i_out_ready               - result consumer ready
//          o_state                   - current FSM state
//          o_in_ready, o_out_valid   - stream handshake outputs
//          o_accept                  - a sample is taken this cycle
//          o_clear                   - accepted beat opens a new frame
//          o_close                   - accepted beat closes the frame
//          o_beat_next               - beat count including this beat
module sklansky_acc_ctrl
  import sklansky_frame_accumulator_pkg::*;
#(
  parameter int SAMPLES = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  input  logic              i_in_last,
  input  logic              i_out_ready,
  output acc_state_t        o_state,
  output logic              o_in_ready,
  output logic              o_out_valid,
  output logic              o_accept,
  output logic              o_clear,
  output logic              o_close,
  output logic [BEAT_W-1:0] o_beat_next
);

  localparam logic [BEAT_W-1:0] SAMPLES_B = BEAT_W'(SAMPLES);

  acc_state_t        r_state;
  acc_state_t        w_state_next;
  logic [BEAT_W-1:0] r_beat_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (o_accept) begin
        r_beat_cnt <= o_beat_next;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, ACCUM: begin
        if (o_close) begin
          w_state_next = DONE;
        end else if (o_accept) begin
          w_state_next = ACCUM;
        end
      end
      DONE: begin
        if (i_out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The first beat in IDLE restarts the count at 1 regardless of any stale
  // count left over from the previous frame.
  always_comb begin
    o_state     = r_state;
    o_in_ready  = (r_state != DONE);
    o_out_valid = (r_state == DONE);
    o_accept    = i_in_valid & (r_state != DONE);
    o_beat_next = (r_state == IDLE) ? BEAT_W'(1) : r_beat_cnt + BEAT_W'(1);
    o_clear     = o_accept & (r_state == IDLE);
    o_close     = o_accept & (i_in_last | (o_beat_next == SAMPLES_B));
  end

endmodule

// File: rtl/sklansky_frame_accumulator.sv
// rtl/sklansky_frame_accumulator.sv - frame summing shell around a 16-bit Sklansky adder
//
// Purpose: sums a frame of 16-bit samples, extends precision by counting adder
//          carry-outs (saturating), and presents one registered result per frame.
// Ports:   i_clk - clock
//          i_rst - synchronous active-high reset
//          bus   - slave side of the sample/result stream interface
module sklansky_frame_accumulator
  import sklansky_frame_accumulator_pkg::*;
#(
  parameter int SAMPLES = 8,
  parameter int CNT_W   = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  sklansky_frame_accumulator_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  acc_state_t              w_state;
  logic                    w_in_ready;
  logic                    w_out_valid;
  logic                    w_accept;
  logic                    w_clear;
  logic                    w_close;
  logic [BEAT_W-1:0]       w_beat_next;
  logic [DATA_W-1:0]       w_a;
  logic [DATA_W-1:0]       w_sum;
  logic                    w_co;
  logic [CNT_W-1:0]        w_carry_next;
  logic                    w_ovf_next;

  logic [DATA_W-1:0]       r_acc;
  logic [CNT_W-1:0]        r_carry_cnt;
  logic                    r_ovf;
  logic [DATA_W+CNT_W-1:0] r_out_sum;
  logic [BEAT_W-1:0]       r_out_cnt;
  logic                    r_out_ovf;

  sklansky_acc_ctrl #(
    .SAMPLES (SAMPLES)
  ) u_ctrl (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_in_valid  (bus.in_valid),
    .i_in_last   (bus.in_last),
    .i_out_ready (bus.out_ready),
    .o_state     (w_state),
    .o_in_ready  (w_in_ready),
    .o_out_valid (w_out_valid),
    .o_accept    (w_accept),
    .o_clear     (w_clear),
    .o_close     (w_close),
    .o_beat_next (w_beat_next)
  );

  // In IDLE the accumulator may still hold the previous frame, so the adder
  // sees zero instead and the first beat loads the sample directly.
  assign w_a = (w_state == IDLE) ? '0 : r_acc;

  SklanskyAdder_16 u_adder (
    .i_a   (w_a),
    .i_b   (bus.in_data),
    .o_sum (w_sum),
    .o_co  (w_co)
  );

  always_comb begin
    w_carry_next = r_carry_cnt;
    w_ovf_next   = r_ovf;
    if (w_clear) begin
      w_carry_next = {{(CNT_W-1){1'b0}}, w_co};
      w_ovf_next   = 1'b0;
    end else if (w_co) begin
      if (r_carry_cnt == CNT_MAX) begin
        w_ovf_next = 1'b1;
      end else begin
        w_carry_next = r_carry_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc       <= '0;
      r_carry_cnt <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_cnt   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc       <= w_sum;
        r_carry_cnt <= w_carry_next;
        r_ovf       <= w_ovf_next;
      end
      // Result registers capture the closing beat's values and then hold
      // untouched through DONE, since no beat is accepted there.
      if (w_close) begin
        r_out_sum <= {w_carry_next, w_sum};
        r_out_cnt <= w_beat_next;
        r_out_ovf <= w_ovf_next;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_cnt   = r_out_cnt;
  assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_sklansky_frame_accumulator.sv
// tb/tb_sklansky_frame_accumulator.sv - directed self-checking bench for the frame accumulator
module tb_sklansky_frame_accumulator;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sklansky_frame_accumulator_if #(.CNT_W(8)) bus_a ();
  sklansky_frame_accumulator_if #(.CNT_W(2)) bus_b ();

  sklansky_frame_accumulator #(.SAMPLES(4), .CNT_W(8)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a.slave)
  );

  sklansky_frame_accumulator #(.SAMPLES(8), .CNT_W(2)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [15:0] d, input logic last);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    bus_a.in_last  = last;
    step();
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] d, input logic last);
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = d;
    bus_b.in_last  = last;
    step();
    bus_b.in_valid = 1'b0;
    bus_b.in_last  = 1'b0;
  endtask

  task automatic take_a(input string tag);
    bus_a.out_ready = 1'b1;
    step();
    bus_a.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus_a.out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(bus_a.in_ready), 32'd1);
  endtask

  task automatic expect_a(input string tag, input logic [31:0] sum, input logic [31:0] cnt, input logic ovf);
    chk({tag, "_valid"}, 32'(bus_a.out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(bus_a.out_sum), sum);
    chk({tag, "_cnt"}, 32'(bus_a.out_cnt), cnt);
    chk({tag, "_ovf"}, 32'(bus_a.out_ovf), 32'(ovf));
  endtask

  logic [23:0] held_sum;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_last = 1'b0; bus_b.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_out_sum", 32'(bus_a.out_sum), 32'd0);
    chk("rst_out_cnt", 32'(bus_a.out_cnt), 32'd0);
    chk("rst_out_ovf", 32'(bus_a.out_ovf), 32'd0);
    chk("rst_b_out_valid", 32'(bus_b.out_valid), 32'd0);

    // 1: 1,2,3,4 with an idle gap carrying junk data/last (must be ignored)
    send_a(16'd1, 1'b0);
    send_a(16'd2, 1'b0);
    bus_a.in_data = 16'hFFFF; bus_a.in_last = 1'b1;
    step();
    step();
    bus_a.in_last = 1'b0;
    chk("t1_gap_no_valid", 32'(bus_a.out_valid), 32'd0);
    send_a(16'd3, 1'b0);
    send_a(16'd4, 1'b0);
    expect_a("t1", 32'h00000A, 32'd4, 1'b0);
    take_a("t1");

    // 2: 0xFFFF x4
    for (int k = 0; k < 4; k++) send_a(16'hFFFF, 1'b0);
    expect_a("t2", 32'h03FFFC, 32'd4, 1'b0);
    take_a("t2");

    // 3: early last, then a fresh single-beat frame
    send_a(16'h8000, 1'b0);
    send_a(16'h8000, 1'b1);
    expect_a("t3a", 32'h010000, 32'd2, 1'b0);
    take_a("t3a");
    send_a(16'd5, 1'b1);
    expect_a("t3b", 32'h000005, 32'd1, 1'b0);
    take_a("t3b");

    // 4: backpressure for 10 cycles, IN_LAST on the SAMPLES-th beat
    send_a(16'h1234, 1'b0);
    send_a(16'h1111, 1'b0);
    send_a(16'h0001, 1'b0);
    send_a(16'h0002, 1'b1);
    expect_a("t4", 32'h002348, 32'd4, 1'b0);
    held_sum = bus_a.out_sum;
    bus_a.in_valid = 1'b1; bus_a.in_data = 16'h0100;
    for (int k = 0; k < 10; k++) begin
      chk("t4_in_ready_low", 32'(bus_a.in_ready), 32'd0);
      chk("t4_hold_valid", 32'(bus_a.out_valid), 32'd1);
      chk("t4_hold_sum", 32'(bus_a.out_sum), 32'(held_sum));
      chk("t4_hold_cnt", 32'(bus_a.out_cnt), 32'd4);
      step();
    end
    bus_a.in_valid = 1'b0;
    take_a("t4");
    // The 0x100 offered in DONE must not have leaked into the next frame.
    send_a(16'd9, 1'b1);
    expect_a("t4_after", 32'h000009, 32'd1, 1'b0);
    take_a("t4_after");

    // 5: CNT_W=2, SAMPLES=8 saturation
    for (int k = 0; k < 7; k++) begin
      send_b(16'hFFFF, 1'b0);
      chk("t5_not_done", 32'(bus_b.out_valid), 32'd0);
    end
    send_b(16'hFFFF, 1'b0);
    chk("t5_valid", 32'(bus_b.out_valid), 32'd1);
    chk("t5_sum", 32'(bus_b.out_sum), 32'h3FFF8);
    chk("t5_cnt", 32'(bus_b.out_cnt), 32'd8);
    chk("t5_ovf", 32'(bus_b.out_ovf), 32'd1);
    bus_b.out_ready = 1'b1;
    step();
    bus_b.out_ready = 1'b0;
    chk("t5_valid_drop", 32'(bus_b.out_valid), 32'd0);

    // 6: reset mid-frame, then 7 x4
    send_a(16'd100, 1'b0);
    send_a(16'd200, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_after_rst_valid", 32'(bus_a.out_valid), 32'd0);
    chk("t6_after_rst_ready", 32'(bus_a.in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      send_a(16'd7, 1'b0);
      chk("t6_no_early_out", 32'(bus_a.out_valid), 32'd0);
    end
    send_a(16'd7, 1'b0);
    expect_a("t6", 32'h00001C, 32'd4, 1'b0);
    take_a("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
